pkt_fifo_commit: RTL and testbench
==================================

Name: pkt_fifo_commit

Overview:
Single-clock, parametrised packet FIFO with frame-level commit and rollback, for the Ethernet RX/TX byte paths.
- Writer pushes words tagged with an end-of-data (EOD) bit.
- A frame becomes visible to the reader only when its EOD word is written.
- A frame can be discarded mid-stream (drop_in), for example on a bad FCS; the write pointer then rolls back to the last commit point.
- Overflowed frames are discarded automatically.
- Reports occupancy, almost-full, almost-empty and a count of complete packets.

Parameters:
DW, 8, data width in bits (EOD is stored alongside as one extra bit)
AW, 14, address width; depth = 2**AW words
AEMPTY_CNT, 1500, aempty asserted when committed level <= this value
AFULL_CNT, 16000, afull asserted when total level (committed + speculative) >= this value
PCW, 8, width of the packet counter

Ports:
clk  in  1  single clock for write and read
arst_n  in  1  asynchronous active-low reset, synchronised internally via sync_2ff (async assert, sync release)
di  in  DW  write data
we  in  1  write request
eod_in  in  1  marks di as the last word of a frame
drop_in  in  1  discard the current uncommitted frame
dout  out  DW  read data
eod_out  out  1  EOD tag of dout
rd_valid  out  1  dout/eod_out valid; one cycle after an accepted read
re  in  1  read request
empty  out  1  no committed words
aempty  out  1  registered almost-empty
full  out  1  total level = 2**AW
afull  out  1  registered almost-full
pkt_avail  out  1  pkt_cnt != 0
pkt_cnt  out  PCW  complete frames stored
level  out  AW+1  committed words (cadr - radr)
ovf_drop  out  1  one-cycle pulse: a frame was discarded because of overflow
usr_drop  out  1  one-cycle pulse: a frame was discarded by drop_in

Behaviour:
- Pointers, each AW+1 bits with a wrap bit:
  - wadr: speculative write pointer.
  - cadr: commit pointer.
  - radr: read pointer.
  - Full: wadr and radr have equal low AW bits and differing MSB.
  - Empty: cadr == radr.
- Write accept: wacc = we & ~full & ~ovf_flag & ~drop_in. On wacc, mem[wadr] <= {di, eod_in} and wadr increments.
- Commit: on wacc & eod_in, cadr <= wadr+1 in the same cycle as the write. The frame is readable the following cycle.
- User drop: drop_in (with or without we) sets wadr <= cadr and clears ovf_flag; usr_drop pulses. drop_in wins over a simultaneous eod_in, so that frame is not committed. drop_in with no open frame is harmless, but still pulses usr_drop.
- Overflow:
  - we & full sets ovf_flag; later writes of that frame are ignored.
  - When we & eod_in arrives while ovf_flag is set or full: wadr <= cadr, ovf_flag clears, ovf_drop pulses.
  - The next frame starts clean.
- Read:
  - racc = re & ~empty.
  - Synchronous RAM read; dout/eod_out are registered and rd_valid = racc delayed by one cycle.
  - dout holds its value when rd_valid = 0.
  - re while empty is ignored; radr does not move.
- Packet count:
  - +1 on commit; -1 when rd_valid & eod_out.
  - When both happen in the same cycle, the count is unchanged.
  - Saturates at 2**PCW-1 and never underflows.
- Flags:
  - afull <= (wadr - radr) >= AFULL_CNT.
  - aempty <= (cadr - radr) <= AEMPTY_CNT.
  - Both are registered, so they lag pointers by one cycle.
  - All subtraction is done in AW+1 bits, modulo 2**(AW+1).
- Wrap-around: pointers roll over naturally, and the MSB disambiguates full from empty. Rollback across the wrap point is handled correctly because the assignment is a plain pointer copy.
- Simultaneous events: commit and read in the same cycle are independent. Writing while the last free slot is read is allowed because full is evaluated on the current pointers.
- Reset values:
  - All pointers = 0; ovf_flag = 0.
  - empty = 1, aempty = 1, full = 0, afull = 0.
  - pkt_cnt = 0, pkt_avail = 0, level = 0.
  - rd_valid = 0, dout = 0, eod_out = 0, ovf_drop = 0, usr_drop = 0.
- Reset mid-frame discards everything, including committed data. RAM contents are not cleared.

Test Plan:
- Reset; write a 4-word frame 0x11..0x44 with EOD on the last word.
  - empty stays 1 until the cycle after the EOD write.
  - Then pkt_cnt = 1 and level = 4.
  - Four reads give 0x11..0x44 with rd_valid one cycle later and eod_out = 1 only on 0x44; after that pkt_cnt = 0 and empty = 1.
- Write 3 words, then pulse drop_in.
  - usr_drop pulses; level stays 0; empty stays 1.
  - A following 2-word frame reads back correctly.
- AW = 4 (16 words): commit a 10-word frame, then write a 10-word frame.
  - full asserts after 6 words of the second frame.
  - The EOD of the second frame produces an ovf_drop pulse; pkt_cnt stays 1 and level stays 10.
- Pointer wrap: with AW = 4, run 40 back-to-back 5-word frames with concurrent reads.
  - No data corruption, no false full or empty, and pkt_cnt never exceeds 3.
- Same cycle: commit of frame B while the EOD word of frame A is read → pkt_cnt unchanged at 1.
- Assert arst_n low mid-frame with 2 packets stored → all flags and counters return to their reset values; afull/aempty at defaults AFULL_CNT = 16000 and AEMPTY_CNT = 1500 track level changes with one cycle of lag.

Source files
------------

// File: rtl/pkt_fifo_commit.sv
// Single-clock packet FIFO with frame commit/rollback, overflow discard and packet counting.
// Reset is asserted asynchronously and released synchronously through sync_2ff.

module sync_2ff (
  input  logic clk,
  input  logic arst_n,
  output logic rst_n
);
  logic meta;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      meta  <= 1'b0;
      rst_n <= 1'b0;
    end else begin
      meta  <= 1'b1;
      rst_n <= meta;
    end
  end
endmodule

module pkt_fifo_commit #(
  parameter int          DW         = 8,
  parameter int          AW         = 14,
  parameter int unsigned AEMPTY_CNT = 1500,
  parameter int unsigned AFULL_CNT  = 16000,
  parameter int          PCW        = 8
) (
  input  logic          clk,
  input  logic          arst_n,
  input  logic [DW-1:0] di,
  input  logic          we,
  input  logic          eod_in,
  input  logic          drop_in,
  output logic [DW-1:0] dout,
  output logic          eod_out,
  output logic          rd_valid,
  input  logic          re,
  output logic          empty,
  output logic          aempty,
  output logic          full,
  output logic          afull,
  output logic          pkt_avail,
  output logic [PCW-1:0] pkt_cnt,
  output logic [AW:0]   level,
  output logic          ovf_drop,
  output logic          usr_drop
);
  localparam int DEPTH = 2**AW;
  localparam logic [PCW-1:0] PKT_MAX = '1;

  logic rst_n;
  sync_2ff u_rst_sync (.clk(clk), .arst_n(arst_n), .rst_n(rst_n));

  logic [DW:0] mem [DEPTH];
  logic [AW:0] wadr, cadr, radr;
  logic        ovf_flag;
  logic        full_i, empty_i, wacc, racc, commit, ovf_evt, pkt_dec;
  logic [AW:0] tot_lvl, com_lvl;

  assign full_i  = (wadr[AW-1:0] == radr[AW-1:0]) && (wadr[AW] != radr[AW]);
  assign empty_i = (cadr == radr);
  assign wacc    = we & ~full_i & ~ovf_flag & ~drop_in;
  assign commit  = wacc & eod_in;
  // An EOD arriving on an overflowed (or currently full) frame closes it out as a discard.
  assign ovf_evt = ~drop_in & we & eod_in & (ovf_flag | full_i);
  assign racc    = re & ~empty_i;
  assign tot_lvl = wadr - radr;
  assign com_lvl = cadr - radr;
  assign pkt_dec = rd_valid & eod_out;

  assign full      = full_i;
  assign empty     = empty_i;
  assign level     = com_lvl;
  assign pkt_avail = (pkt_cnt != '0);

  always_ff @(posedge clk) begin
    if (wacc) mem[wadr[AW-1:0]] <= {di, eod_in};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wadr     <= '0;
      cadr     <= '0;
      ovf_flag <= 1'b0;
      usr_drop <= 1'b0;
      ovf_drop <= 1'b0;
    end else begin
      usr_drop <= drop_in;
      ovf_drop <= ovf_evt;
      if (drop_in) begin
        wadr     <= cadr;
        ovf_flag <= 1'b0;
      end else if (ovf_evt) begin
        wadr     <= cadr;
        ovf_flag <= 1'b0;
      end else if (we & full_i) begin
        ovf_flag <= 1'b1;
      end else if (wacc) begin
        wadr <= wadr + 1'b1;
        if (eod_in) cadr <= wadr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      radr     <= '0;
      rd_valid <= 1'b0;
      dout     <= '0;
      eod_out  <= 1'b0;
    end else begin
      rd_valid <= racc;
      if (racc) begin
        {dout, eod_out} <= mem[radr[AW-1:0]];
        radr            <= radr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_cnt <= '0;
    end else if (commit && !pkt_dec) begin
      if (pkt_cnt != PKT_MAX) pkt_cnt <= pkt_cnt + 1'b1;
    end else if (pkt_dec && !commit) begin
      if (pkt_cnt != '0) pkt_cnt <= pkt_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      afull  <= 1'b0;
      aempty <= 1'b1;
    end else begin
      afull  <= 32'(tot_lvl) >= AFULL_CNT;
      aempty <= 32'(com_lvl) <= AEMPTY_CNT;
    end
  end
endmodule

// File: tb/tb_pkt_fifo_commit.sv
// Bench for pkt_fifo_commit: a small (16-word) instance checked against a queue model, plus
// a default-size instance for the almost-full / almost-empty thresholds.

module tb_pkt_fifo_commit;
  localparam int S_DEPTH = 16;
  localparam int S_AEMPTY = 3;
  localparam int S_AFULL = 12;

  logic clk = 1'b0;
  logic arst_n = 1'b1;
  always #5 clk = ~clk;

  logic [7:0] s_di, s_dout, s_pkt_cnt;
  logic       s_we, s_eod, s_drop, s_re, s_eod_out, s_rd_valid, s_empty, s_aempty;
  logic       s_full, s_afull, s_pkt_avail, s_ovf_drop, s_usr_drop;
  logic [4:0] s_level;

  logic [7:0]  d_di, d_dout, d_pkt_cnt;
  logic        d_we, d_eod, d_drop, d_re, d_eod_out, d_rd_valid, d_empty, d_aempty;
  logic        d_full, d_afull, d_pkt_avail, d_ovf_drop, d_usr_drop;
  logic [14:0] d_level;

  pkt_fifo_commit #(.DW(8), .AW(4), .AEMPTY_CNT(S_AEMPTY), .AFULL_CNT(S_AFULL), .PCW(8)) u_small (
    .clk(clk), .arst_n(arst_n), .di(s_di), .we(s_we), .eod_in(s_eod), .drop_in(s_drop),
    .dout(s_dout), .eod_out(s_eod_out), .rd_valid(s_rd_valid), .re(s_re), .empty(s_empty),
    .aempty(s_aempty), .full(s_full), .afull(s_afull), .pkt_avail(s_pkt_avail),
    .pkt_cnt(s_pkt_cnt), .level(s_level), .ovf_drop(s_ovf_drop), .usr_drop(s_usr_drop));

  pkt_fifo_commit u_dflt (
    .clk(clk), .arst_n(arst_n), .di(d_di), .we(d_we), .eod_in(d_eod), .drop_in(d_drop),
    .dout(d_dout), .eod_out(d_eod_out), .rd_valid(d_rd_valid), .re(d_re), .empty(d_empty),
    .aempty(d_aempty), .full(d_full), .afull(d_afull), .pkt_avail(d_pkt_avail),
    .pkt_cnt(d_pkt_cnt), .level(d_level), .ovf_drop(d_ovf_drop), .usr_drop(d_usr_drop));

  int total = 0;
  int bad = 0;

  // Reference model: committed words readable, speculative words of the open frame.
  logic [8:0] cq[$];
  logic [8:0] sq[$];
  bit         m_ovf, m_eodo, m_rv, m_ovfd, m_usrd, m_afull, m_aempty;
  logic [7:0] m_dout;
  int         m_pkt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    cq.delete();
    sq.delete();
    m_ovf = 0; m_eodo = 0; m_rv = 0; m_ovfd = 0; m_usrd = 0;
    m_afull = 0; m_aempty = 1; m_dout = 8'h00; m_pkt = 0;
  endtask

  task automatic check_small();
    int tot;
    tot = cq.size() + sq.size();
    chk("s_empty",     32'(s_empty),     32'(cq.size() == 0));
    chk("s_level",     32'(s_level),     32'(cq.size()));
    chk("s_full",      32'(s_full),      32'(tot == S_DEPTH));
    chk("s_pkt_cnt",   32'(s_pkt_cnt),   32'(m_pkt));
    chk("s_pkt_avail", 32'(s_pkt_avail), 32'(m_pkt != 0));
    chk("s_rd_valid",  32'(s_rd_valid),  32'(m_rv));
    chk("s_dout",      32'(s_dout),      32'(m_dout));
    chk("s_eod_out",   32'(s_eod_out),   32'(m_eodo));
    chk("s_ovf_drop",  32'(s_ovf_drop),  32'(m_ovfd));
    chk("s_usr_drop",  32'(s_usr_drop),  32'(m_usrd));
    chk("s_afull",     32'(s_afull),     32'(m_afull));
    chk("s_aempty",    32'(s_aempty),    32'(m_aempty));
  endtask

  // Advance the model by one clock using the inputs currently applied, then compare.
  task automatic tick();
    int tot, lvl;
    bit fullm, emptym, inc, dec;
    logic [8:0] w;
    tot = cq.size() + sq.size();
    lvl = cq.size();
    fullm = (tot == S_DEPTH);
    emptym = (lvl == 0);
    dec = m_rv & m_eodo;
    inc = 0;
    m_ovfd = 0;
    m_usrd = 0;
    m_afull = (tot >= S_AFULL);
    m_aempty = (lvl <= S_AEMPTY);
    if (s_re && !emptym) begin
      w = cq.pop_front();
      m_dout = w[8:1];
      m_eodo = w[0];
      m_rv = 1;
    end else begin
      m_rv = 0;
    end
    if (s_drop) begin
      sq.delete(); m_ovf = 0; m_usrd = 1;
    end else if (s_we) begin
      if (s_eod && (m_ovf || fullm)) begin
        sq.delete(); m_ovf = 0; m_ovfd = 1;
      end else if (fullm) begin
        m_ovf = 1;
      end else if (!m_ovf) begin
        sq.push_back({s_di, s_eod});
        if (s_eod) begin
          foreach (sq[k]) cq.push_back(sq[k]);
          sq.delete();
          inc = 1;
        end
      end
    end
    if (inc && !dec && m_pkt < 255) m_pkt++;
    else if (dec && !inc && m_pkt > 0) m_pkt--;
    @(posedge clk);
    #1;
    check_small();
  endtask

  task automatic scyc(input bit we, input logic [7:0] di, input bit eod, input bit drop, input bit re);
    s_we = we; s_di = di; s_eod = eod; s_drop = drop; s_re = re;
    tick();
  endtask

  task automatic do_reset();
    s_we = 0; s_di = 0; s_eod = 0; s_drop = 0; s_re = 0;
    d_we = 0; d_di = 0; d_eod = 0; d_drop = 0; d_re = 0;
    arst_n = 1'b0;
    #1;
    model_reset();
    check_small();
    repeat (2) @(posedge clk);
    #1;
    arst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_small();
  endtask

  initial begin
    logic [7:0] b;
    s_we = 0; s_di = 0; s_eod = 0; s_drop = 0; s_re = 0;
    d_we = 0; d_di = 0; d_eod = 0; d_drop = 0; d_re = 0;
    repeat (3) @(posedge clk);
    #1;
    do_reset();

    // basic 4-word frame, then read back
    for (int i = 0; i < 4; i++) begin
      b = 8'(8'h11 * (i + 1));
      scyc(1, b, i == 3, 0, 0);
    end
    scyc(0, 0, 0, 0, 0);
    chk("t1_pkt_cnt", 32'(s_pkt_cnt), 32'd1);
    chk("t1_level", 32'(s_level), 32'd4);
    for (int i = 0; i < 4; i++) scyc(0, 0, 0, 0, 1);
    scyc(0, 0, 0, 0, 0);
    chk("t1_pkt_end", 32'(s_pkt_cnt), 32'd0);
    scyc(0, 0, 0, 0, 0);

    // user drop mid-frame, then a clean 2-word frame
    for (int i = 0; i < 3; i++) scyc(1, 8'(8'h50 + i), 0, 0, 0);
    scyc(0, 0, 0, 1, 0);
    chk("t2_usr_drop", 32'(s_usr_drop), 32'd1);
    scyc(1, 8'hA1, 0, 0, 0);
    scyc(1, 8'hA2, 1, 0, 0);
    scyc(0, 0, 0, 0, 0);
    scyc(0, 0, 0, 0, 1);
    scyc(0, 0, 0, 0, 1);
    scyc(0, 0, 0, 0, 0);
    scyc(0, 0, 0, 0, 0);

    // overflow: 10-word frame committed, 10-word frame overflows
    for (int i = 0; i < 10; i++) scyc(1, 8'(8'h60 + i), i == 9, 0, 0);
    for (int i = 0; i < 10; i++) begin
      scyc(1, 8'(8'h80 + i), i == 9, 0, 0);
      if (i == 5) chk("t3_full_at6", 32'(s_full), 32'd1);
    end
    chk("t3_ovf_drop", 32'(s_ovf_drop), 32'd1);
    chk("t3_pkt_cnt", 32'(s_pkt_cnt), 32'd1);
    chk("t3_level", 32'(s_level), 32'd10);
    for (int i = 0; i < 14; i++) scyc(0, 0, 0, 0, 1);

    // pointer wrap: 40 back-to-back 5-word frames with concurrent reads
    for (int f = 0; f < 40; f++) begin
      for (int k = 0; k < 5; k++) begin
        scyc(1, 8'($urandom), k == 4, 0, 1);
        chk("t4_pkt_le3", 32'(s_pkt_cnt <= 8'd3), 32'd1);
      end
    end
    for (int i = 0; i < 10; i++) scyc(0, 0, 0, 0, 1);

    // commit of frame B in the same cycle frame A's EOD word is delivered
    for (int i = 0; i < 3; i++) scyc(1, 8'(8'hC0 + i), i == 2, 0, 0);
    for (int i = 0; i < 4; i++) scyc(1, 8'(8'hB0 + i), i == 3, 0, i < 3);
    chk("t5_same_cyc_pkt", 32'(s_pkt_cnt), 32'd1);
    for (int i = 0; i < 8; i++) scyc(0, 0, 0, 0, 1);

    // randomized traffic: slow reader first (overflows), faster reader later
    for (int c = 0; c < 1500; c++) begin
      scyc($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 4) == 0,
           $urandom_range(0, 30) == 0,
           (c < 750) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 2) != 0));
    end
    for (int i = 0; i < 20; i++) scyc(0, 0, 0, 0, 1);

    // reset mid-frame with two packets stored
    scyc(1, 8'hD1, 0, 0, 0);
    scyc(1, 8'hD2, 1, 0, 0);
    scyc(1, 8'hD3, 0, 0, 0);
    scyc(1, 8'hD4, 1, 0, 0);
    scyc(1, 8'hD5, 0, 0, 0);
    chk("t6_pre_rst_pkt", 32'(s_pkt_cnt), 32'd2);
    do_reset();
    chk("t6_rst_level", 32'(s_level), 32'd0);
    scyc(1, 8'hE1, 1, 0, 0);
    scyc(0, 0, 0, 0, 1);
    scyc(0, 0, 0, 0, 0);

    // default-size thresholds on the second instance
    do_reset();
    chk("d_rst_aempty", 32'(d_aempty), 32'd1);
    chk("d_rst_afull", 32'(d_afull), 32'd0);
    chk("d_rst_empty", 32'(d_empty), 32'd1);
    chk("d_rst_level", 32'(d_level), 32'd0);
    for (int i = 0; i < 1501; i++) begin
      d_we = 1; d_di = 8'(i); d_eod = (i == 1500);
      @(posedge clk);
      #1;
      if (i == 1499) begin
        chk("d_uncommitted_level", 32'(d_level), 32'd0);
        chk("d_uncommitted_empty", 32'(d_empty), 32'd1);
      end
    end
    chk("d_commit_level", 32'(d_level), 32'd1501);
    chk("d_aempty_lag", 32'(d_aempty), 32'd1);
    chk("d_commit_pkt", 32'(d_pkt_cnt), 32'd1);
    d_we = 0; d_eod = 0;
    @(posedge clk);
    #1;
    chk("d_aempty_clear", 32'(d_aempty), 32'd0);
    for (int i = 0; i < 14499; i++) begin
      d_we = 1; d_di = 8'(i + 7);
      @(posedge clk);
      #1;
    end
    chk("d_afull_lag", 32'(d_afull), 32'd0);
    chk("d_not_full", 32'(d_full), 32'd0);
    d_we = 0;
    @(posedge clk);
    #1;
    chk("d_afull_set", 32'(d_afull), 32'd1);
    d_drop = 1;
    @(posedge clk);
    #1;
    d_drop = 0;
    chk("d_usr_drop", 32'(d_usr_drop), 32'd1);
    chk("d_afull_hold", 32'(d_afull), 32'd1);
    chk("d_level_after_drop", 32'(d_level), 32'd1501);
    @(posedge clk);
    #1;
    chk("d_afull_clear", 32'(d_afull), 32'd0);
    d_re = 1;
    @(posedge clk);
    #1;
    d_re = 0;
    chk("d_level_rd", 32'(d_level), 32'd1500);
    chk("d_rd_valid", 32'(d_rd_valid), 32'd1);
    chk("d_aempty_lag2", 32'(d_aempty), 32'd0);
    @(posedge clk);
    #1;
    chk("d_aempty_set", 32'(d_aempty), 32'd1);
    chk("d_rd_valid_off", 32'(d_rd_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
